// File: rtl/hm01b0_pixel_ingest.sv
// HM01B0 parallel pixel ingest: synchronizes the camera bus into the system clock
// and writes each 8-row strip into five 8x8-MCU-ordered block RAMs, double-buffered.
module hm01b0_pixel_ingest (
  input  logic       clock,
  input  logic       nreset,
  input  logic       hm01b0_pixclk,
  input  logic [7:0] hm01b0_pixdata,
  input  logic       hm01b0_hsync,
  input  logic       hm01b0_vsync,
  output logic [2:0] output_block_select,
  output logic       frontbuffer_select,
  output logic [8:0] output_write_addr,
  output logic [7:0] output_pixval,
  output logic       wren
);

  localparam logic [8:0] LINE_PIXELS = 9'd320;

  // Bus layout inside the synchronizer: {pixclk, hsync, vsync, pixdata[7:0]}
  logic [10:0] sync1_q;
  logic [10:0] sync2_q;
  logic [2:0]  sync3_q;

  logic       pclk_rise_s;
  logic       hs_fall_s;
  logic       vs_rise_s;
  logic       pix_evt_s;
  logic       line_end_s;
  logic [7:0] pix_data_s;

  logic [8:0] x_q, x_d;
  logic [2:0] row_q, row_d;

  logic       pend_wr_q, pend_wr_d;
  logic [2:0] pend_blk_q, pend_blk_d;
  logic [8:0] pend_addr_q, pend_addr_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       pend_tog_q, pend_tog_d;

  logic       wren_q;
  logic       fb_q;
  logic [2:0] blk_q;
  logic [8:0] addr_q;
  logic [7:0] data_q;

  // Two-flop synchronizer for the whole bus plus an edge-detect delay on the strobes
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= 11'd0;
      sync2_q <= 11'd0;
      sync3_q <= 3'd0;
    end else begin
      sync1_q <= {hm01b0_pixclk, hm01b0_hsync, hm01b0_vsync, hm01b0_pixdata};
      sync2_q <= sync1_q;
      sync3_q <= sync2_q[10:8];
    end
  end

  assign pclk_rise_s = sync2_q[10] & ~sync3_q[2];
  assign hs_fall_s   = ~sync2_q[9] & sync3_q[1];
  assign vs_rise_s   = sync2_q[8] & ~sync3_q[0];
  assign pix_evt_s   = pclk_rise_s & sync2_q[9] & sync2_q[8];
  assign line_end_s  = hs_fall_s & sync2_q[8];
  assign pix_data_s  = sync2_q[7:0];

  // Pixel is captured with the old x/row before any end-of-line or start-of-frame update
  always_comb begin
    x_d         = x_q;
    row_d       = row_q;
    pend_wr_d   = 1'b0;
    pend_blk_d  = pend_blk_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_tog_d  = 1'b0;
    if (pix_evt_s) begin
      if (x_q < LINE_PIXELS) begin
        pend_wr_d   = 1'b1;
        pend_blk_d  = x_q[8:6];
        pend_addr_d = {x_q[5:3], row_q, x_q[2:0]};
        pend_data_d = pix_data_s;
        x_d         = x_q + 9'd1;
      end else begin
        x_d = x_q;
      end
    end else begin
      x_d = x_q;
    end
    if (line_end_s) begin
      x_d        = 9'd0;
      row_d      = row_q + 3'd1;
      pend_tog_d = (row_q == 3'd7);
    end else begin
      row_d = row_q;
    end
    if (vs_rise_s) begin
      x_d        = 9'd0;
      row_d      = 3'd0;
      pend_tog_d = 1'b0;
    end else begin
      pend_tog_d = pend_tog_d;
    end
  end

  // Counter and capture stage
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      x_q         <= 9'd0;
      row_q       <= 3'd0;
      pend_wr_q   <= 1'b0;
      pend_blk_q  <= 3'd0;
      pend_addr_q <= 9'd0;
      pend_data_q <= 8'd0;
      pend_tog_q  <= 1'b0;
    end else begin
      x_q         <= x_d;
      row_q       <= row_d;
      pend_wr_q   <= pend_wr_d;
      pend_blk_q  <= pend_blk_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_tog_q  <= pend_tog_d;
    end
  end

  // Registered RAM-side outputs; address/data hold until the next write
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      wren_q <= 1'b0;
      fb_q   <= 1'b0;
      blk_q  <= 3'd0;
      addr_q <= 9'd0;
      data_q <= 8'd0;
    end else begin
      wren_q <= pend_wr_q;
      if (pend_wr_q) begin
        blk_q  <= pend_blk_q;
        addr_q <= pend_addr_q;
        data_q <= pend_data_q;
      end
      if (pend_tog_q) begin
        fb_q <= ~fb_q;
      end
    end
  end

  assign wren                = wren_q;
  assign frontbuffer_select  = fb_q;
  assign output_block_select = blk_q;
  assign output_write_addr   = addr_q;
  assign output_pixval       = data_q;

endmodule

// File: tb/tb_hm01b0_pixel_ingest.sv
// Scoreboard bench for hm01b0_pixel_ingest: a frame/line/pixel model predicts every
// RAM write (with its arrival cycle) and every bank toggle; monitors compare.
module tb_hm01b0_pixel_ingest;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       pixclk = 1'b0;
  logic [7:0] pixdata = 8'd0;
  logic       hsync = 1'b0;
  logic       vsync = 1'b0;
  logic [2:0] blk;
  logic       fb;
  logic [8:0] addr;
  logic [7:0] pixval;
  logic       wren;

  hm01b0_pixel_ingest dut (
    .clock               (clock),
    .nreset              (nreset),
    .hm01b0_pixclk       (pixclk),
    .hm01b0_pixdata      (pixdata),
    .hm01b0_hsync        (hsync),
    .hm01b0_vsync        (vsync),
    .output_block_select (blk),
    .frontbuffer_select  (fb),
    .output_write_addr   (addr),
    .output_pixval       (pixval),
    .wren                (wren)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       bank;
    logic [2:0] blk;
    logic [8:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  logic tog_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state: frame active, current strip row, current bank
  bit   m_vs = 1'b0;
  int   m_row = 0;
  logic m_bank = 1'b0;

  logic prev_wren = 1'b0;
  logic fb_prev = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // write monitor
  always @(negedge clock) begin
    if (!nreset) begin
      prev_wren <= 1'b0;
    end else begin
      if (wren) begin
        chk("wren_single_cycle", {31'd0, prev_wren}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wren: got blk %0d addr 0x%0h data 0x%0h, expected no write", blk, addr, pixval);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("write_bank_blk_addr_data", {11'd0, fb, blk, addr, pixval},
              {11'd0, e.bank, e.blk, e.addr, e.data});
          chk("write_latency_cycle", cyc, e.cyc);
        end
      end
      prev_wren <= wren;
    end
  end

  // bank toggle monitor
  always @(negedge clock) begin
    if (!nreset) begin
      fb_prev = 1'b0;
    end else if (fb !== fb_prev) begin
      if (tog_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_toggle: got frontbuffer_select %0b, expected no toggle", fb);
      end else begin
        chk("toggle_value", {31'd0, fb}, {31'd0, tog_q.pop_front()});
      end
      fb_prev = fb;
    end
  end

  task automatic pix(input logic [7:0] d, input int x);
    @(posedge clock);
    #3;
    pixdata = d;
    pixclk  = 1'b1;
    if (m_vs && hsync && x < 320) begin
      exp_t e;
      e.bank = m_bank;
      e.blk  = 3'(x / 64);
      e.addr = 9'(((x % 64) / 8) * 64 + m_row * 8 + (x % 8));
      e.data = d;
      e.cyc  = cyc + 4;
      exp_q.push_back(e);
    end
    repeat (2) @(posedge clock);
    #3 pixclk = 1'b0;
    @(posedge clock);
  endtask

  // kind 0: value = x mod 256, otherwise random bytes
  task automatic line(input int n, input int kind);
    logic [7:0] d;
    @(posedge clock);
    #3 hsync = 1'b1;
    repeat (3) @(posedge clock);
    for (int i = 0; i < n; i++) begin
      d = (kind == 0) ? 8'(i % 256) : 8'($urandom_range(0, 255));
      pix(d, i);
    end
    repeat (2) @(posedge clock);
    #3 hsync = 1'b0;
    if (m_vs) begin
      m_row = (m_row + 1) % 8;
      if (m_row == 0) begin
        m_bank = ~m_bank;
        tog_q.push_back(m_bank);
      end
    end
    repeat (6) @(posedge clock);
  endtask

  task automatic frame_start();
    @(posedge clock);
    #3 vsync = 1'b1;
    m_vs  = 1'b1;
    m_row = 0;
    repeat (6) @(posedge clock);
  endtask

  task automatic frame_end();
    @(posedge clock);
    #3 vsync = 1'b0;
    m_vs = 1'b0;
    repeat (6) @(posedge clock);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_wren"}, {31'd0, wren}, 32'd0);
    chk({tag, "_fb"}, {31'd0, fb}, 32'd0);
    chk({tag, "_blk"}, {29'd0, blk}, 32'd0);
    chk({tag, "_addr"}, {23'd0, addr}, 32'd0);
    chk({tag, "_pixval"}, {24'd0, pixval}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    check_outputs_zero("reset");
    #3 nreset = 1'b1;
    repeat (4) @(posedge clock);

    // strip 1: full lines, first one with value = x mod 256
    frame_start();
    line(320, 0);
    for (int l = 1; l < 8; l++) line(320, 1);
    chk("bank_after_strip1", {31'd0, fb}, {31'd0, m_bank});

    // strip 2: random lengths including overlong lines
    line(324, 1);
    line(324, 1);
    for (int l = 2; l < 8; l++) line($urandom_range(1, 324), 1);
    chk("bank_after_strip2", {31'd0, fb}, {31'd0, m_bank});

    // aborted frame after 5 lines, idle activity, then a fresh frame
    for (int l = 0; l < 5; l++) line($urandom_range(1, 40), 1);
    frame_end();
    line(12, 1);
    line(12, 1);
    chk("bank_after_abort", {31'd0, fb}, {31'd0, m_bank});
    frame_start();
    for (int l = 0; l < 8; l++) line($urandom_range(1, 40), 1);
    chk("bank_after_new_frame_strip", {31'd0, fb}, {31'd0, m_bank});

    // reset in the middle of a line
    @(posedge clock);
    #3 hsync = 1'b1;
    repeat (3) @(posedge clock);
    for (int i = 0; i < 5; i++) pix(8'($urandom_range(0, 255)), i);
    repeat (8) @(posedge clock);
    #2 nreset = 1'b0;
    #1 check_outputs_zero("midline_reset");
    hsync  = 1'b0;
    pixclk = 1'b0;
    m_row  = 0;
    m_bank = 1'b0;
    repeat (3) @(posedge clock);
    #3 nreset = 1'b1;
    repeat (6) @(posedge clock);
    line(40, 1);
    line(20, 0);

    for (int w = 0; w < 50 && (exp_q.size() != 0 || tog_q.size() != 0); w++) @(posedge clock);
    chk("write_queue_drained", exp_q.size(), 32'd0);
    chk("toggle_queue_drained", tog_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hm01b0_pixel_ingest.md
# hm01b0_pixel_ingest

- Captures the HM01B0 camera's 8-bit parallel pixel stream into the system clock domain.
- Reorders each 8-row strip of a 320-column frame into 8×8 MCU order across five 512-byte block RAMs, and double-buffers strips by toggling a bank select.
- Sits between the camera pins and the JPEG strip buffers. Downstream DCT control watches `frontbuffer_select` toggles to start processing the completed bank.

## Interface
Parameters:
- none. Geometry is fixed: 320 active columns, 5 blocks × 64 columns, 8-row strips.

Ports:
- `clock`  in  1  system clock; must be ≥ 4× `hm01b0_pixclk` frequency.
- `nreset`  in  1  reset; one clock, reset is asynchronous and active-low.
- `hm01b0_pixclk`  in  1  camera pixel clock; asynchronous to `clock`.
- `hm01b0_pixdata`  in  8  pixel byte; valid at `hm01b0_pixclk` rising edge.
- `hm01b0_hsync`  in  1  line valid; high during a line's active pixels.
- `hm01b0_vsync`  in  1  frame valid; high during a frame.
- `output_block_select`  out  3  target block RAM index, 0..4 (column / 64).
- `frontbuffer_select`  out  1  bank currently being written; RAM writes go to bank `frontbuffer_select`.
- `output_write_addr`  out  9  {col[5:3], row[2:0], col[2:0]}, where col is column mod 64 and row is line mod 8.
- `output_pixval`  out  8  pixel byte to write.
- `wren`  out  1  one-cycle write strobe.

## Operation
- **Synchronizer:** `hm01b0_pixclk`, `hm01b0_hsync`, `hm01b0_vsync` and `hm01b0_pixdata` each pass through an identical 2-flop synchronizer, followed by a third delay register for edge detection.
- **Pixel event:** a synchronized pixclk rising edge while synchronized hsync and vsync are both high.
- **Counters:** `x` (0..319 plus saturating overflow) and `row` (0..7).
- **Pixel write:** if x < 320, register the following and pulse `wren`:
  - `output_pixval` = synced data;
  - `output_block_select` = x[8:6];
  - `output_write_addr` = {x[5:3], row, x[2:0]}.
- **Pixel advance:** x increments on every pixel event. Pixels with x ≥ 320 produce no write, and x saturates without wrapping.
- **End of line:** on a synchronized hsync falling edge (while vsync is high):
  - x ← 0;
  - row ← row + 1, wrapping mod 8;
  - when row wraps 7→0, `frontbuffer_select` toggles on the same edge.
- **Short lines:** a line shorter than 320 pixels still advances row on its hsync fall. Unwritten locations keep stale data.
- **Start of frame:** on a synchronized vsync rising edge, x ← 0 and row ← 0. `frontbuffer_select` is not changed, so a partial strip from an aborted frame is discarded.
- **Idle:** while vsync is low, no writes and no toggles occur.
- **Strobe rule:** `wren` is never high on two consecutive cycles; the clock ratio guarantees this.

## Timing
- **Reset values:** all synchronizer and counter registers, plus all outputs, are 0: `wren` = 0, `frontbuffer_select` = 0, addr/data/select = 0. Reset acts immediately and asynchronously. Reset mid-line drops the line and restarts at x = 0, row = 0, bank 0.
- **Write latency:** count the first `clock` edge that samples pixclk high as edge 1; `wren` is high for exactly one cycle after edge 4. Data, addr and select are valid in that same cycle and hold until the next write.
- **Toggle latency:** `frontbuffer_select` toggles the same 4-edge latency after hsync falls, always after the strip's last `wren`.
- **Row ordering:** the row increment takes effect before the next line's first pixel event. This requires at least 4 `clock` cycles between hsync fall and the next pixclk rise with hsync high.
- **Simultaneous events:** a pixel event and a hsync fall detected in the same cycle process the pixel first (written with the old row), then apply the end-of-line update.

## Test plan
- **Reset:** assert nreset low mid-line → all outputs 0 immediately; after release, the first pixel of the next line writes block 0, addr 0, bank 0.
- **Single line:** stream 320 pixels, value = x mod 256, on row 0 → 320 `wren` pulses. x = 0 writes block 0, addr 0x000; x = 63 writes block 0, addr 0x1C7; x = 64 writes block 1, addr 0x000; x = 319 writes block 4, addr 0x1C7.
- **Row addressing:** line 3, x = 10 → block 0, addr {001, 011, 010} = 0x05A.
- **Strip toggle:** 8 full lines → `frontbuffer_select` goes 0→1 after the 8th hsync fall and no earlier. 16 lines → back to 0. 2560 writes per strip.
- **Overlong line:** 324 pixels per line → the 4 extra pixels produce no `wren`, and row still advances exactly once.
- **Aborted frame:** vsync drops after 5 lines, then a new frame starts → row restarts at 0 with no toggle. Check latency: `wren` 4 edges after pixclk is sampled high, with clock:pixclk = 4:1.
